// File: rtl/signed_divider.sv
// Sequential signed restoring divider: one quotient bit per cycle, then a sign fix.
// Optional divide-by-zero flag port dz enabled by defining DIVIDER_DZ_FLAG_EN.
module signed_divider #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SIZE-1:0]   data_in,
    output logic [2*SIZE-1:0] data_out,
    output logic              done
`ifdef DIVIDER_DZ_FLAG_EN
    ,
    output logic              dz
`endif
);

    localparam int CNT_W = $clog2(SIZE + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_FIX    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              a_neg_q, a_neg_d;
    logic              b_neg_q, b_neg_d;
    logic [SIZE-1:0]   quo_q, quo_d;
    logic [SIZE-1:0]   rem_q, rem_d;
    logic [SIZE-1:0]   div_q, div_d;
    logic [2*SIZE-1:0] data_out_q, data_out_d;
    logic              done_q, done_d;
`ifdef DIVIDER_DZ_FLAG_EN
    logic              dz_q, dz_d;
`endif

    // Magnitudes fit in SIZE unsigned bits: |-2^(SIZE-1)| = 2^(SIZE-1).
    logic [SIZE-1:0] in_mag;
    logic [SIZE:0]   shifted;
    logic            take;
    logic            div_zero;

    // Operand magnitude and restoring-division trial step.
    always_comb begin
        in_mag   = data_in[SIZE-1] ? ({SIZE{1'b0}} - data_in) : data_in;
        shifted  = {rem_q, quo_q[SIZE-1]};
        take     = (shifted >= {1'b0, div_q});
        div_zero = (div_q == {SIZE{1'b0}});
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        a_neg_d    = a_neg_q;
        b_neg_d    = b_neg_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        div_d      = div_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
        dz_d       = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                a_neg_d = data_in[SIZE-1];
                quo_d   = in_mag;
                rem_d   = {SIZE{1'b0}};
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_neg_d = data_in[SIZE-1];
                div_d   = in_mag;
                count_d = CNT_W'(SIZE);
                state_d = S_CALC;
            end
            S_CALC: begin
                // A zero divisor leaves |dividend| intact in quo for FIX.
                if (!div_zero) begin
                    rem_d = take ? (shifted[SIZE-1:0] - div_q)
                                 : shifted[SIZE-1:0];
                    quo_d = {quo_q[SIZE-2:0], take};
                end
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_zero) begin
                    quo_d = {SIZE{1'b1}};
                    rem_d = a_neg_q ? ({SIZE{1'b0}} - quo_q) : quo_q;
                end else begin
                    quo_d = (a_neg_q ^ b_neg_q) ? ({SIZE{1'b0}} - quo_q)
                                                : quo_q;
                    rem_d = a_neg_q ? ({SIZE{1'b0}} - rem_q) : rem_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                data_out_d = {rem_q, quo_q};
                done_d     = 1'b1;
`ifdef DIVIDER_DZ_FLAG_EN
                dz_d       = div_zero;
`endif
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
`ifdef DIVIDER_DZ_FLAG_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
`ifdef DIVIDER_DZ_FLAG_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;
`ifdef DIVIDER_DZ_FLAG_EN
    assign dz       = dz_q;
`endif

endmodule
